// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB types and register index constants
package apb_pkg;

  typedef enum logic [1:0] {
    M_IDLE,
    M_SETUP,
    M_ACCESS
  } mst_state_t;

  typedef enum logic {
    S_IDLE,
    S_ACCESS
  } slv_state_t;

  localparam int REG_ID     = 0;
  localparam int REG_STATUS = 1;
  localparam int REG_CTRL   = 2;

endpackage

// File: rtl/apb_regfile.sv
// rtl/apb_regfile.sv - word register file: RO id/status words, RW control words
module apb_regfile
  import apb_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter int                    IDX_W      = 4,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'hA9B0_0001
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]      raddr,
  input  logic [DATA_WIDTH-1:0] status,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] ctrl
);

  logic [DATA_WIDTH-1:0] rw_q [NUM_REGS];

  // Entries REG_ID and REG_STATUS exist in the array but are never written.
  always_ff @(posedge pclk) begin
    if (preset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rw_q[i] <= '0;
      end
    end else if (we && int'(waddr) >= REG_CTRL && int'(waddr) < NUM_REGS) begin
      rw_q[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    if (int'(raddr) == REG_ID) begin
      rdata = ID_VALUE;
    end else if (int'(raddr) == REG_STATUS) begin
      rdata = status;
    end else if (int'(raddr) < NUM_REGS) begin
      rdata = rw_q[raddr];
    end
  end

  assign ctrl = rw_q[REG_CTRL];

endmodule

// File: rtl/apb_slave.sv
// rtl/apb_slave.sv - APB completer with programmable wait states and error response
module apb_slave
  import apb_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_REGS    = 16,
  parameter int                    WAIT_CYCLES = 1,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  pselx,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic                  pready,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pslverr,
  input  logic [DATA_WIDTH-1:0] status_i,
  output logic [DATA_WIDTH-1:0] ctrl_o
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0]      CNT_LOAD   = CNT_W'(WAIT_CYCLES);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(NUM_REGS * 4);

  slv_state_t            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic                  wr_q;
  logic                  err_q;
  logic [IDX_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] status_q;
  logic [DATA_WIDTH-1:0] rf_rdata;

  logic             setup;
  logic             complete;
  logic [IDX_W-1:0] setup_idx;
  logic             setup_err;

  assign setup     = (state_q == S_IDLE) && pselx && !penable;
  assign complete  = (state_q == S_ACCESS) && pselx && penable && (cnt_q == '0);
  assign setup_idx = paddr[IDX_W+1:2];
  assign setup_err = (paddr[1:0] != 2'b00) || (paddr >= ADDR_LIMIT) ||
                     (pwrite && (int'(setup_idx) < REG_CTRL));

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (pselx && !penable) state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (!pselx) state_d = S_IDLE;
        else if (penable && cnt_q == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Transfer attributes are frozen at setup; later bus changes are ignored.
  always_ff @(posedge pclk) begin
    if (preset) begin
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      status_q <= '0;
    end else if (setup) begin
      cnt_q    <= CNT_LOAD;
      wr_q     <= pwrite;
      err_q    <= setup_err;
      idx_q    <= setup_idx;
      wdata_q  <= pwdata;
      status_q <= status_i;
    end else if (state_q == S_ACCESS && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  always_comb begin
    pready  = (state_q == S_ACCESS) && (cnt_q == '0);
    pslverr = pready && err_q;
    prdata  = '0;
    if (pready && !wr_q && !err_q) prdata = rf_rdata;
  end

  apb_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (IDX_W),
    .ID_VALUE   (ID_VALUE)
  ) u_regfile (
    .pclk   (pclk),
    .preset (preset),
    .we     (complete && wr_q && !err_q),
    .waddr  (idx_q),
    .wdata  (wdata_q),
    .raddr  (idx_q),
    .status (status_q),
    .rdata  (rf_rdata),
    .ctrl   (ctrl_o)
  );

endmodule

// File: tb/tb_apb_slave.sv
// tb/tb_apb_slave.sv - self-checking bench for apb_slave with one and zero wait states
module tb_apb_slave;

  localparam int          NR = 16;
  localparam logic [31:0] ID = 32'hA9B0_0001;

  logic        pclk = 1'b0;
  logic        preset  [2];
  logic        pselx   [2];
  logic        penable [2];
  logic        pwrite  [2];
  logic [31:0] paddr   [2];
  logic [31:0] pwdata  [2];
  logic [31:0] status  [2];
  logic        pready  [2];
  logic        pslverr [2];
  logic [31:0] prdata  [2];
  logic [31:0] ctrl    [2];

  logic        exp_pready  [2];
  logic        exp_pslverr [2];
  logic [31:0] exp_prdata  [2];
  logic [31:0] exp_ctrl    [2];
  logic [31:0] model [2][NR];

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 pclk = ~pclk;

  apb_slave #(.WAIT_CYCLES(1)) u_dut_w1 (
    .pclk(pclk), .preset(preset[0]), .pselx(pselx[0]), .penable(penable[0]),
    .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]), .pready(pready[0]),
    .prdata(prdata[0]), .pslverr(pslverr[0]), .status_i(status[0]), .ctrl_o(ctrl[0])
  );

  apb_slave #(.WAIT_CYCLES(0)) u_dut_w0 (
    .pclk(pclk), .preset(preset[1]), .pselx(pselx[1]), .penable(penable[1]),
    .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]), .pready(pready[1]),
    .prdata(prdata[1]), .pslverr(pslverr[1]), .status_i(status[1]), .ctrl_o(ctrl[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge pclk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("dut%0d_pready", d),  32'(pready[d]),  32'(exp_pready[d]));
        check($sformatf("dut%0d_pslverr", d), 32'(pslverr[d]), 32'(exp_pslverr[d]));
        check($sformatf("dut%0d_prdata", d),  prdata[d], exp_prdata[d]);
        check($sformatf("dut%0d_ctrl", d),    ctrl[d],   exp_ctrl[d]);
      end
    end
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic drive_idle(input int d);
    pselx[d]       = 1'b0;
    penable[d]     = 1'b0;
    pwrite[d]      = 1'b0;
    exp_pready[d]  = 1'b0;
    exp_pslverr[d] = 1'b0;
    exp_prdata[d]  = '0;
  endtask

  task automatic clear_model(input int d);
    for (int i = 0; i < NR; i++) model[d][i] = '0;
    exp_ctrl[d] = '0;
  endtask

  function automatic bit model_err(input bit wr, input logic [31:0] addr);
    return (addr % 4 != 0) || (addr >= NR * 4) || (wr && (addr / 4) < 2);
  endfunction

  // One complete transfer; lat is the access cycle (1-based) in which pready was seen, 0 if never.
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                      output logic [31:0] rd, output bit err, output int lat);
    int          w   = (d == 0) ? 1 : 0;
    bit          e   = model_err(wr, addr);
    int          idx = int'(addr / 4);
    logic [31:0] exp_rd;
    exp_rd = '0;
    if (!wr && !e) exp_rd = (idx == 0) ? ID : (idx == 1) ? status[d] : model[d][idx];
    pselx[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr; pwdata[d] = data;
    tick();
    lat = 0; rd = '0; err = 1'b0;
    for (int k = 0; k <= w; k++) begin
      penable[d]     = 1'b1;
      pwdata[d]      = ~data;
      status[d]      = status[d] + 32'h0101_0101;
      exp_pready[d]  = (k == w);
      exp_pslverr[d] = (k == w) && e;
      exp_prdata[d]  = (k == w) ? exp_rd : '0;
      @(negedge pclk);
      if (pready[d] && lat == 0) begin
        lat = k + 1; rd = prdata[d]; err = pslverr[d];
      end
      tick();
    end
    if (wr && !e) begin
      model[d][idx] = data;
      if (idx == 2) exp_ctrl[d] = data;
    end
    drive_idle(d);
  endtask

  initial begin
    logic [31:0] rd;
    bit          err;
    int          lat;

    for (int d = 0; d < 2; d++) begin
      preset[d] = 1'b1; paddr[d] = '0; pwdata[d] = '0;
      drive_idle(d);
      clear_model(d);
    end
    status[0] = 32'h1234_0000;
    status[1] = 32'h5678_0000;
    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset_pready%0d", d),  32'(pready[d]),  32'h0);
      check($sformatf("reset_prdata%0d", d),  prdata[d],       32'h0);
      check($sformatf("reset_pslverr%0d", d), 32'(pslverr[d]), 32'h0);
      check($sformatf("reset_ctrl%0d", d),    ctrl[d],         32'h0);
      preset[d] = 1'b0;
    end
    chk_en = 1'b1;
    tick();

    // One wait state: write ctrl then read it back
    xfer(0, 1, 32'h08, 32'hDEAD_BEEF, rd, err, lat);
    check("w1_write_lat", 32'(lat), 32'd2);
    check("w1_write_err", 32'(err), 32'd0);
    check("w1_ctrl_next", ctrl[0], 32'hDEAD_BEEF);
    xfer(0, 0, 32'h08, 32'h0, rd, err, lat);
    check("w1_read08", rd, 32'hDEAD_BEEF);
    check("w1_read_lat", 32'(lat), 32'd2);

    // ID register is read-only
    xfer(0, 0, 32'h00, 32'h0, rd, err, lat);
    check("id_read", rd, 32'hA9B0_0001);
    xfer(0, 1, 32'h00, 32'hFFFF_FFFF, rd, err, lat);
    check("id_write_err", 32'(err), 32'd1);
    xfer(0, 0, 32'h00, 32'h0, rd, err, lat);
    check("id_readback", rd, 32'hA9B0_0001);

    // Status sampled at setup despite changing during access
    status[0] = 32'hC0DE_0042;
    xfer(0, 0, 32'h04, 32'h0, rd, err, lat);
    check("status_read", rd, 32'hC0DE_0042);
    xfer(0, 1, 32'h04, 32'h1, rd, err, lat);
    check("status_write_err", 32'(err), 32'd1);

    // Out-of-range, misaligned and last-register boundaries
    xfer(0, 0, 32'h40, 32'h0, rd, err, lat);
    check("oob_err", 32'(err), 32'd1);
    check("oob_rd", rd, 32'h0);
    xfer(0, 0, 32'h09, 32'h0, rd, err, lat);
    check("misalign_err", 32'(err), 32'd1);
    check("misalign_rd", rd, 32'h0);
    xfer(0, 1, 32'h3C, 32'h0000_1357, rd, err, lat);
    check("last_write_err", 32'(err), 32'd0);
    xfer(0, 0, 32'h3C, 32'h0, rd, err, lat);
    check("last_read", rd, 32'h0000_1357);

    // Zero wait states, back-to-back transfers
    xfer(1, 1, 32'h0C, 32'h5, rd, err, lat);
    check("w0_write_lat", 32'(lat), 32'd1);
    xfer(1, 0, 32'h0C, 32'h0, rd, err, lat);
    check("w0_read0c", rd, 32'h5);
    check("w0_read_lat", 32'(lat), 32'd1);
    xfer(1, 1, 32'h08, 32'h0BAD_F00D, rd, err, lat);
    xfer(1, 0, 32'h08, 32'h0, rd, err, lat);
    check("w0_ctrl_b2b", rd, 32'h0BAD_F00D);

    // penable in idle is ignored
    pselx[1] = 1'b1; penable[1] = 1'b1; pwrite[1] = 1'b1; paddr[1] = 32'h10; pwdata[1] = 32'h55;
    tick();
    drive_idle(1);
    tick();
    xfer(1, 0, 32'h10, 32'h0, rd, err, lat);
    check("pen_idle_read", rd, 32'h0);

    // Master abort during access: no write, no response
    pselx[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 32'h14; pwdata[0] = 32'h9;
    tick();
    drive_idle(0);
    tick();
    xfer(0, 0, 32'h14, 32'h0, rd, err, lat);
    check("abort_read", rd, 32'h0);

    // Reset in the middle of an access drops the write
    pselx[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 32'h10; pwdata[0] = 32'h7;
    tick();
    penable[0] = 1'b1; preset[0] = 1'b1;
    tick();
    preset[0] = 1'b0;
    drive_idle(0);
    clear_model(0);
    check("rst_mid_pready", 32'(pready[0]), 32'h0);
    check("rst_mid_ctrl", ctrl[0], 32'h0);
    tick();
    xfer(0, 0, 32'h10, 32'h0, rd, err, lat);
    check("rst_mid_read10", rd, 32'h0);
    check("rst_mid_lat", 32'(lat), 32'd2);

    tick();
    tick();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
